// File: rtl/irq_ctrl_u_pkg.sv
// Shared definitions for the external-interrupt controller: FSM states and
// the mcause base value for external interrupt channels.
package irq_ctrl_u_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2,
      SVC  = 2'd3
   } irq_state_t;

   localparam logic [31:0] IRQ_CAUSE_BASE = 32'h8000_0010;

   // A single-channel controller still needs a 1-bit id port.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/irq_ctrl_u_sync.sv
// Per-channel synchroniser for active-low asynchronous requests, plus a delay
// flop so the controller can see falling edges of the synchronised level.
module irq_ctrl_u_sync #(
   parameter int N      = 3,
   parameter int STAGES = 2
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] async_n,
   output logic [N-1:0] sync_low,
   output logic [N-1:0] fall
);

   logic [N-1:0] stage_reg [STAGES];
   logic [N-1:0] prev_reg;

   // Flops reset to 1 (inactive) so reset release never fakes an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < STAGES; s++) stage_reg[s] <= '1;
         prev_reg <= '1;
      end else begin
         stage_reg[0] <= async_n;
         for (int s = 1; s < STAGES; s++) stage_reg[s] <= stage_reg[s-1];
         prev_reg <= stage_reg[STAGES-1];
      end
   end

   assign sync_low = ~stage_reg[STAGES-1];
   assign fall     = prev_reg & ~stage_reg[STAGES-1];

endmodule

// File: rtl/irq_ctrl_u.sv
// External-interrupt controller: synchronised level/edge pending latches,
// masking, fixed lowest-index priority and a trap/ack/service handshake FSM.
module irq_ctrl_u
   import irq_ctrl_u_pkg::*;
#(
   parameter int               N_IRQ       = 3,
   parameter int               SYNC_STAGES = 2,
   parameter logic [N_IRQ-1:0] EDGE_MASK   = '0,
   parameter int               ACK_CYCLES  = 1,
   localparam int              IDW         = id_width(N_IRQ)
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_IRQ-1:0] oint_n,
   input  logic [N_IRQ-1:0] irq_en,
   input  logic             mie_global,
   input  logic             core_ready,
   input  logic             irq_taken,
   input  logic             mret_done,
   output logic             irq_req,
   output logic [IDW-1:0]   irq_id,
   output logic [31:0]      irq_cause,
   output logic [N_IRQ-1:0] irq_pending,
   output logic             iack_n
);

   irq_state_t             state_reg;
   logic [N_IRQ-1:0]       pend_reg, pend_next;
   logic [N_IRQ-1:0]       sync_low, fall, cand, clr_vec;
   logic [(1<<IDW)-1:0]    cand_ext;
   logic [IDW-1:0]         id_reg, win_id;
   logic                   req_reg, iack_n_reg, mret_seen_reg, take;
   logic [3:0]             ack_cnt_reg;

   irq_ctrl_u_sync #(
      .N      (N_IRQ),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_n  (oint_n),
      .sync_low (sync_low),
      .fall     (fall)
   );

   assign cand = pend_reg & irq_en & {N_IRQ{mie_global}};
   assign take = (state_reg == REQ) && irq_taken;

   always_comb begin
      cand_ext = '0;
      cand_ext[N_IRQ-1:0] = cand;
   end

   // Walk from the top down so the lowest set index wins.
   always_comb begin
      win_id = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (cand[i]) win_id = IDW'(i);
      end
   end

   generate
      for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_clr
         assign clr_vec[gi] = take && (id_reg == IDW'(gi));
      end
   endgenerate

   // Edge channels: a new fall dominates a same-cycle acknowledge clear.
   assign pend_next = (EDGE_MASK & (fall | (pend_reg & ~clr_vec)))
                    | (~EDGE_MASK & sync_low);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         pend_reg      <= '0;
         id_reg        <= '0;
         req_reg       <= 1'b0;
         iack_n_reg    <= 1'b1;
         ack_cnt_reg   <= '0;
         mret_seen_reg <= 1'b0;
      end else begin
         pend_reg <= pend_next;
         case (state_reg)
            IDLE: begin
               if ((|cand) && core_ready) begin
                  state_reg <= REQ;
                  req_reg   <= 1'b1;
                  id_reg    <= win_id;
               end
            end
            REQ: begin
               if (irq_taken) begin
                  state_reg     <= ACK;
                  req_reg       <= 1'b0;
                  iack_n_reg    <= 1'b0;
                  ack_cnt_reg   <= 4'(ACK_CYCLES - 1);
                  mret_seen_reg <= 1'b0;
               end else if (!cand_ext[id_reg]) begin
                  state_reg <= IDLE;
                  req_reg   <= 1'b0;
               end
            end
            ACK: begin
               if (mret_done) mret_seen_reg <= 1'b1;
               if (ack_cnt_reg == 4'd0) begin
                  iack_n_reg <= 1'b1;
                  // A handler that already returned skips the service wait.
                  state_reg  <= (mret_seen_reg || mret_done) ? IDLE : SVC;
               end else begin
                  ack_cnt_reg <= ack_cnt_reg - 4'd1;
               end
            end
            SVC: begin
               if (mret_done) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign irq_req     = req_reg;
   assign irq_id      = id_reg;
   assign irq_pending = pend_reg;
   assign iack_n      = iack_n_reg;
   assign irq_cause   = IRQ_CAUSE_BASE + 32'(id_reg);

endmodule
